// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC controller: PC width, reset vector,
// FSM state encoding and the IF/ID pipeline record.
package fetch_pkg;

  localparam int unsigned PC_W = 16;
  localparam logic [PC_W-1:0] RESET_VECTOR = 16'h0000;
  localparam logic [PC_W-1:0] PC_STEP = 16'h0002;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc_curr;
    logic [PC_W-1:0] pc_next;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            valid;
  } if_id_t;

  // Sequential successor; the 16-bit result wraps 0xFFFE to 0x0000.
  function automatic logic [PC_W-1:0] pc_seq(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: load on enable, synchronous clear (reset or flush)
// has priority over the load.
module if_id_pipe_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  input  logic   clr_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t if_id_q;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      if_id_q <= '0;
    end else if (en_i) begin
      if_id_q <= d_i;
    end
  end

  assign q_o = if_id_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller with branch prediction redirect, stall handling
// and HLT freeze. Define BRANCH_STATS_EN to add saturating branch counters.
module fetch_pc_ctrl
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            predicted_taken,
  input  logic            btb_hit,
  input  logic [PC_W-1:0] predicted_target,
  input  logic            ID_branch,
  input  logic            ID_actual_taken,
  input  logic [PC_W-1:0] ID_actual_target,
  input  logic            ID_halt,
  output logic [PC_W-1:0] PC_curr,
  output logic [PC_W-1:0] IF_ID_PC_curr,
  output logic [PC_W-1:0] IF_ID_PC_next,
  output logic            IF_ID_predicted_taken,
  output logic [PC_W-1:0] IF_ID_predicted_target,
  output logic            IF_ID_valid,
  output logic            BHT_wen,
  output logic            BTB_wen,
  output logic            actual_taken_out,
  output logic            flush,
  output logic            halted,
  output logic [15:0]     branch_count,
  output logic [15:0]     mispredict_count
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  if_id_t          if_id_d, if_id_q;

  logic            active;
  logic            pred_hit;
  logic [PC_W-1:0] pc_seq_w;
  logic [PC_W-1:0] pred_next;
  logic            resolve;
  logic            mispredict;
  logic            halt_go;
  logic            if_id_en;
  logic            if_id_clr;

  assign active    = (state_q != ST_HALT);
  assign pred_hit  = predicted_taken && btb_hit;
  assign pc_seq_w  = pc_seq(pc_q);
  assign pred_next = pred_hit ? predicted_target : pc_seq_w;

  assign resolve    = active && if_id_q.valid && ID_branch && !stall;
  assign mispredict = resolve &&
                      ((ID_actual_taken != if_id_q.pred_taken) ||
                       (ID_actual_taken && (ID_actual_target != if_id_q.pred_target)));
  assign halt_go    = (state_q == ST_FETCH) && if_id_q.valid && ID_halt &&
                      !stall && !mispredict;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (halt_go) state_d = ST_HALT;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (active) begin
      if (mispredict) begin
        pc_d = ID_actual_taken ? ID_actual_target : if_id_q.pc_next;
      end else if (!stall) begin
        pc_d = pred_next;
      end
    end
  end

  // pc_next keeps the fall-through address so a wrongly-taken prediction
  // can recover to the sequential path.
  always_comb begin
    if_id_d.pc_curr     = pc_q;
    if_id_d.pc_next     = pc_seq_w;
    if_id_d.pred_taken  = pred_hit;
    if_id_d.pred_target = predicted_target;
    if_id_d.valid       = 1'b1;
  end

  assign if_id_en  = !stall || mispredict;
  assign if_id_clr = mispredict || halt_go || !active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_pipe_reg u_if_id (
    .clk   (clk),
    .rst   (rst),
    .en_i  (if_id_en),
    .clr_i (if_id_clr),
    .d_i   (if_id_d),
    .q_o   (if_id_q)
  );

`ifdef BRANCH_STATS_EN
  logic [15:0] branch_count_q, mispredict_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (resolve && (branch_count_q != 16'hFFFF)) begin
        branch_count_q <= branch_count_q + 16'd1;
      end
      if (mispredict && (mispredict_count_q != 16'hFFFF)) begin
        mispredict_count_q <= mispredict_count_q + 16'd1;
      end
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  assign branch_count     = 16'h0000;
  assign mispredict_count = 16'h0000;
`endif

  assign PC_curr                = pc_q;
  assign IF_ID_PC_curr          = if_id_q.pc_curr;
  assign IF_ID_PC_next          = if_id_q.pc_next;
  assign IF_ID_predicted_taken  = if_id_q.pred_taken;
  assign IF_ID_predicted_target = if_id_q.pred_target;
  assign IF_ID_valid            = if_id_q.valid;

  assign BHT_wen          = resolve;
  assign BTB_wen          = resolve && ID_actual_taken &&
                            (!if_id_q.pred_taken || (ID_actual_target != if_id_q.pred_target));
  assign actual_taken_out = ID_actual_taken;
  assign flush            = mispredict;
  assign halted           = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl; expected counter values
// follow BRANCH_STATS_EN when the bench is built with it.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        predicted_taken;
  logic        btb_hit;
  logic [15:0] predicted_target;
  logic        ID_branch;
  logic        ID_actual_taken;
  logic [15:0] ID_actual_target;
  logic        ID_halt;
  logic [15:0] PC_curr;
  logic [15:0] IF_ID_PC_curr;
  logic [15:0] IF_ID_PC_next;
  logic        IF_ID_predicted_taken;
  logic [15:0] IF_ID_predicted_target;
  logic        IF_ID_valid;
  logic        BHT_wen;
  logic        BTB_wen;
  logic        actual_taken_out;
  logic        flush;
  logic        halted;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  int checks = 0;
  int failures = 0;
  int exp_br = 0;
  int exp_mp = 0;

  fetch_pc_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall                  (stall),
    .predicted_taken        (predicted_taken),
    .btb_hit                (btb_hit),
    .predicted_target       (predicted_target),
    .ID_branch              (ID_branch),
    .ID_actual_taken        (ID_actual_taken),
    .ID_actual_target       (ID_actual_target),
    .ID_halt                (ID_halt),
    .PC_curr                (PC_curr),
    .IF_ID_PC_curr          (IF_ID_PC_curr),
    .IF_ID_PC_next          (IF_ID_PC_next),
    .IF_ID_predicted_taken  (IF_ID_predicted_taken),
    .IF_ID_predicted_target (IF_ID_predicted_target),
    .IF_ID_valid            (IF_ID_valid),
    .BHT_wen                (BHT_wen),
    .BTB_wen                (BTB_wen),
    .actual_taken_out       (actual_taken_out),
    .flush                  (flush),
    .halted                 (halted),
    .branch_count           (branch_count),
    .mispredict_count       (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input logic taken, input logic hit, input logic [15:0] tgt);
    predicted_taken  = taken;
    btb_hit          = hit;
    predicted_target = tgt;
  endtask

  task automatic branch(input logic taken, input logic [15:0] tgt);
    ID_branch        = 1'b1;
    ID_actual_taken  = taken;
    ID_actual_target = tgt;
  endtask

  task automatic no_branch();
    ID_branch        = 1'b0;
    ID_actual_taken  = 1'b0;
    ID_actual_target = 16'h0000;
  endtask

  task automatic check_counters(input string tag);
`ifdef BRANCH_STATS_EN
    check({tag, "_branch_count"}, branch_count, exp_br);
    check({tag, "_mispredict_count"}, mispredict_count, exp_mp);
`else
    check({tag, "_branch_count"}, branch_count, 0);
    check({tag, "_mispredict_count"}, mispredict_count, 0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    ID_halt = 1'b0;
    predict(1'b0, 1'b0, 16'h0000);
    no_branch();
    step();
    step();
    check("rst_pc", PC_curr, 16'h0000);
    check("rst_valid", IF_ID_valid, 0);
    check("rst_halted", halted, 0);
    check_counters("rst");

    // IDLE cycle, then the first sequential fetch
    rst = 1'b0;
    #1;
    check("idle_pc", PC_curr, 16'h0000);
    check("idle_valid", IF_ID_valid, 0);
    step();
    check("first_seq_pc", PC_curr, 16'h0002);
    check("first_ifid_valid", IF_ID_valid, 1);
    check("first_ifid_pc", IF_ID_PC_curr, 16'h0000);
    check("first_ifid_next", IF_ID_PC_next, 16'h0002);

    // correct prediction: 0x0010 predicted taken to 0x0040
    predict(1'b1, 1'b1, 16'h0010);
    step();
    check("jump_to_10", PC_curr, 16'h0010);
    predict(1'b1, 1'b1, 16'h0040);
    step();
    check("pred_taken_pc", PC_curr, 16'h0040);
    check("pred_ifid_pc", IF_ID_PC_curr, 16'h0010);
    check("pred_ifid_taken", IF_ID_predicted_taken, 1);
    check("pred_ifid_target", IF_ID_predicted_target, 16'h0040);
    predict(1'b0, 1'b0, 16'h0000);
    branch(1'b1, 16'h0040);
    #1;
    check("ok_flush", flush, 0);
    check("ok_bht_wen", BHT_wen, 1);
    check("ok_btb_wen", BTB_wen, 0);
    check("ok_taken_out", actual_taken_out, 1);
    check("ok_bht_index", IF_ID_PC_curr[3:0], 4'h0);
    exp_br++;
    step();
    no_branch();
    check("ok_next_pc", PC_curr, 16'h0042);
    check("ok_next_valid", IF_ID_valid, 1);

    // mispredict: 0x0010 predicted not taken, resolves taken to 0x0080
    predict(1'b1, 1'b1, 16'h0010);
    step();
    predict(1'b0, 1'b0, 16'h0000);
    step();
    check("mp_pc_before", PC_curr, 16'h0012);
    check("mp_ifid_pc", IF_ID_PC_curr, 16'h0010);
    check("mp_ifid_taken", IF_ID_predicted_taken, 0);
    branch(1'b1, 16'h0080);
    #1;
    check("mp_flush", flush, 1);
    check("mp_btb_wen", BTB_wen, 1);
    check("mp_bht_wen", BHT_wen, 1);
    exp_br++;
    exp_mp++;
    step();
    no_branch();
    check("mp_redirect_pc", PC_curr, 16'h0080);
    check("mp_valid_cleared", IF_ID_valid, 0);

    // stall held over a mispredicting branch, redirect once it releases
    step();
    check("post_mp_pc", PC_curr, 16'h0082);
    check("post_mp_ifid_pc", IF_ID_PC_curr, 16'h0080);
    step();
    check("smp_pc", PC_curr, 16'h0084);
    stall = 1'b1;
    branch(1'b1, 16'h0100);
    #1;
    check("smp_stalled_flush", flush, 0);
    check("smp_stalled_bht", BHT_wen, 0);
    check("smp_stalled_btb", BTB_wen, 0);
    step();
    check("smp_hold_pc", PC_curr, 16'h0084);
    check("smp_hold_ifid", IF_ID_PC_curr, 16'h0082);
    check("smp_hold_valid", IF_ID_valid, 1);
    stall = 1'b0;
    #1;
    check("smp_release_flush", flush, 1);
    exp_br++;
    exp_mp++;
    step();
    no_branch();
    check("smp_redirect_pc", PC_curr, 16'h0100);
    check("smp_valid_cleared", IF_ID_valid, 0);

    // stall alone for three cycles
    step();
    check("pre_stall_pc", PC_curr, 16'h0102);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", PC_curr, 16'h0102);
      check("stall_ifid_pc", IF_ID_PC_curr, 16'h0100);
    end
    stall = 1'b0;

    // two correctly predicted not-taken branches
    branch(1'b0, 16'h0000);
    #1;
    check("nt_flush", flush, 0);
    check("nt_bht_wen", BHT_wen, 1);
    check("nt_btb_wen", BTB_wen, 0);
    check("nt_taken_out", actual_taken_out, 0);
    exp_br++;
    step();
    check("nt_pc", PC_curr, 16'h0104);
    check("nt2_flush", flush, 0);
    check("nt2_bht_wen", BHT_wen, 1);
    exp_br++;
    step();
    no_branch();
    check("nt2_pc", PC_curr, 16'h0106);
    check_counters("stats");

    // PC wrap at the top of the address space
    predict(1'b1, 1'b1, 16'hFFFE);
    step();
    check("wrap_at_top", PC_curr, 16'hFFFE);
    predict(1'b0, 1'b0, 16'h0000);
    step();
    check("wrap_pc", PC_curr, 16'h0000);
    check("wrap_ifid_pc", IF_ID_PC_curr, 16'hFFFE);
    check("wrap_ifid_next", IF_ID_PC_next, 16'h0000);

    // HLT in decode freezes the fetch stage
    ID_halt = 1'b1;
    #1;
    check("halt_pre", halted, 0);
    step();
    ID_halt = 1'b0;
    check("halt_asserted", halted, 1);
    check("halt_valid", IF_ID_valid, 0);
    check("halt_pc", PC_curr, 16'h0002);
    predict(1'b1, 1'b1, 16'h0300);
    branch(1'b1, 16'h0400);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("halt_bht_wen", BHT_wen, 0);
      check("halt_btb_wen", BTB_wen, 0);
      check("halt_flush", flush, 0);
      step();
      check("halt_frozen_pc", PC_curr, 16'h0002);
      check("halt_stays", halted, 1);
      check("halt_valid_low", IF_ID_valid, 0);
    end
    no_branch();
    predict(1'b0, 1'b0, 16'h0000);

    // reset leaves HALT
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_pc", PC_curr, 16'h0000);
    check("rst2_halted", halted, 0);
    check("rst2_valid", IF_ID_valid, 0);
    exp_br = 0;
    exp_mp = 0;
    check_counters("rst2");
    step();
    check("rst2_seq1", PC_curr, 16'h0002);
    step();
    check("rst2_seq2", PC_curr, 16'h0004);
    check("rst2_ifid_pc", IF_ID_PC_curr, 16'h0002);

    // reset wins over a redirect in the same cycle
    branch(1'b1, 16'h0200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    no_branch();
    check("rst_redirect_pc", PC_curr, 16'h0000);
    check("rst_redirect_valid", IF_ID_valid, 0);
    check("rst_redirect_ifid_pc", IF_ID_PC_curr, 16'h0000);
    step();
    check("rst_redirect_seq", PC_curr, 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
